// File: rtl/pwm_hit_scheduler.sv
// -----------------------------------------------------------------------------
// pwm_hit_scheduler
//
// Shares one PWM serializer between NUM_REQ strike requesters. One requester is
// granted at a time. The grantee's duty (clamped to DUTY_MAX) is held on
// duty_cycle with hit high for HOLD_WINDOWS PWM windows. A rest of REST_WINDOWS
// windows follows, with hit low and duty_cycle at zero, before the next grant.
//
// Build option:
//   PWM_SCHED_FIXED_PRIORITY_EN - when defined, the lowest requesting index
//                                 always wins and no round-robin pointer is kept.
//                                 When undefined (default), selection is
//                                 round-robin starting after the last grantee.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   req        in   [NUM_REQ]   level request per requester
//   req_duty   in   [7*NUM_REQ] duty of requester i in bits [7i+6:7i]
//   grant      out  [NUM_REQ]   one-hot, one-cycle pulse on acceptance
//   busy       out  high while striking or resting
//   done       out  one-cycle pulse on the first idle cycle after a sequence
//   owner      out  index of the current or last grantee
//   duty_cycle out  [7]         duty to the serializer
//   hit        out  serializer gate
// -----------------------------------------------------------------------------
module pwm_hit_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int SYS_FREQ     = 100,
  parameter int PULSE_FREQ   = 1,
  parameter int HOLD_WINDOWS = 20,
  parameter int REST_WINDOWS = 10,
  parameter int DUTY_MAX     = 99
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [7*NUM_REQ-1:0]       req_duty,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic [6:0]                 duty_cycle,
  output logic                       hit
);

  localparam int OW       = $clog2(NUM_REQ);
  localparam int WIN      = SYS_FREQ / PULSE_FREQ;
  localparam int HOLD_CYC = HOLD_WINDOWS * WIN;
  localparam int REST_CYC = REST_WINDOWS * WIN;
  localparam int MAX_CYC  = (HOLD_CYC > REST_CYC) ? HOLD_CYC : REST_CYC;
  localparam int CW       = $clog2(MAX_CYC) + 1;
  localparam bit HAS_REST = (REST_WINDOWS > 0);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  // With no rest phase the REST state is never entered; keep the constant legal.
  localparam logic [CW-1:0] REST_LAST = CW'(HAS_REST ? (REST_CYC - 1) : 0);
  localparam logic [6:0]    DUTY_CAP  = 7'(DUTY_MAX);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STRIKE = 2'd1;
  localparam logic [1:0] ST_REST   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [6:0]         duty_q, duty_d;
  logic               hit_q, hit_d;

  logic               req_any_s;
  logic [OW-1:0]      win_s;
  logic [6:0]         duty_sel_s;
  logic [6:0]         duty_clamp_s;

`ifndef PWM_SCHED_FIXED_PRIORITY_EN
  logic [OW-1:0]      last_q, last_d;
  logic [OW-1:0]      scan_idx_s;
`endif

  // Winner selection among the currently requesting inputs.
  always_comb begin
    req_any_s = |req;
    win_s     = '0;
`ifdef PWM_SCHED_FIXED_PRIORITY_EN
    // Scan from the top so the lowest requesting index is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      win_s = req[i] ? OW'(i) : win_s;
    end
`else
    // Scan offsets from farthest to nearest after the last grantee, so the
    // nearest requesting index following last_q is written last and wins.
    scan_idx_s = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      scan_idx_s = OW'((int'(last_q) + off) % NUM_REQ);
      win_s      = req[scan_idx_s] ? scan_idx_s : win_s;
    end
`endif
  end

  // Duty of the selected requester, clamped to the ceiling.
  always_comb begin
    duty_sel_s = 7'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      duty_sel_s = (win_s == OW'(i)) ? req_duty[7*i +: 7] : duty_sel_s;
    end
    duty_clamp_s = (duty_sel_s > DUTY_CAP) ? DUTY_CAP : duty_sel_s;
  end

  // Sequencer next-state logic: idle -> strike -> (rest) -> idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    owner_d = owner_q;
    duty_d  = duty_q;
    hit_d   = hit_q;
`ifndef PWM_SCHED_FIXED_PRIORITY_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_any_s) begin
          state_d = ST_STRIKE;
          cnt_d   = '0;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
          busy_d  = 1'b1;
          owner_d = win_s;
          duty_d  = duty_clamp_s;
          hit_d   = 1'b1;
`ifndef PWM_SCHED_FIXED_PRIORITY_EN
          last_d  = win_s;
`endif
        end else begin
          busy_d = 1'b0;
          duty_d = 7'd0;
          hit_d  = 1'b0;
        end
      end
      ST_STRIKE: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d  = '0;
          hit_d  = 1'b0;
          duty_d = 7'd0;
          if (HAS_REST) begin
            state_d = ST_REST;
          end else begin
            // No rest phase: finish on the same edge that drops hit.
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_REST: begin
        if (cnt_q == REST_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        duty_d  = 7'd0;
        hit_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset puts requester 0 at top priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      owner_q <= '0;
      duty_q  <= 7'd0;
      hit_q   <= 1'b0;
`ifndef PWM_SCHED_FIXED_PRIORITY_EN
      last_q  <= OW'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      duty_q  <= duty_d;
      hit_q   <= hit_d;
`ifndef PWM_SCHED_FIXED_PRIORITY_EN
      last_q  <= last_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign owner      = owner_q;
  assign duty_cycle = duty_q;
  assign hit        = hit_q;

endmodule

// File: tb/tb_pwm_hit_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for pwm_hit_scheduler. Stimulus pushes expected grants into a
// queue; a monitor pops and checks them, plus hit length, rest length and done
// timing. A second instance with no rest phase is checked inline.
// -----------------------------------------------------------------------------
module tb_pwm_hit_scheduler;

  localparam int N        = 4;
  localparam int DMAX     = 99;
  localparam int WIN_A    = 100;
  localparam int HOLD_A   = 2;
  localparam int REST_A   = 1;
  localparam int HOLD_CYC = HOLD_A * WIN_A;
  localparam int REST_CYC = REST_A * WIN_A;
  localparam int WIN_B    = 10;
  localparam int HOLD_B   = 1;

  typedef struct {
    int idx;
    int duty;
    bit b2b;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req_a = '0;
  logic [7*N-1:0]   duty_a = '0;
  logic [N-1:0]     grant_a;
  logic             busy_a, done_a, hit_a;
  logic [1:0]       owner_a;
  logic [6:0]       duty_cycle_a;

  logic [N-1:0]     req_b = '0;
  logic [7*N-1:0]   duty_b = {N{7'd30}};
  logic [N-1:0]     grant_b;
  logic             busy_b, done_b, hit_b;
  logic [1:0]       owner_b;
  logic [6:0]       duty_cycle_b;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_a = N - 1;
  int   last_b = N - 1;

  pwm_hit_scheduler #(
    .NUM_REQ(N), .SYS_FREQ(100), .PULSE_FREQ(1),
    .HOLD_WINDOWS(HOLD_A), .REST_WINDOWS(REST_A), .DUTY_MAX(DMAX)
  ) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .req_duty(duty_a),
    .grant(grant_a), .busy(busy_a), .done(done_a), .owner(owner_a),
    .duty_cycle(duty_cycle_a), .hit(hit_a)
  );

  pwm_hit_scheduler #(
    .NUM_REQ(N), .SYS_FREQ(10), .PULSE_FREQ(1),
    .HOLD_WINDOWS(HOLD_B), .REST_WINDOWS(0), .DUTY_MAX(DMAX)
  ) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .req_duty(duty_b),
    .grant(grant_b), .busy(busy_b), .done(done_b), .owner(owner_b),
    .duty_cycle(duty_cycle_b), .hit(hit_b)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference selection: next requesting index after 'last', or lowest index.
  function automatic int pick(int v, int last);
`ifdef PWM_SCHED_FIXED_PRIORITY_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
`else
    for (int off = 1; off <= N; off++) begin
      int c = (last + off) % N;
      if (v[c]) return c;
    end
    return last;
`endif
  endfunction

  function automatic int duty_of(logic [7*N-1:0] d, int w);
    int raw = int'((d >> (7 * w)) & 28'h7F);
    return (raw > DMAX) ? DMAX : raw;
  endfunction

  // Predict g successive grants while vector v is held.
  task automatic push_round(int v, int g);
    for (int k = 0; k < g; k++) begin
      int w = pick(v, last_a);
      last_a = w;
      q.push_back('{idx: w, duty: duty_of(duty_a, w), b2b: (k > 0)});
    end
  endtask

  // Wait until all predicted grants were seen, then drop the requests.
  task automatic drain(int budget);
    int t = 0;
    while (q.size() != 0 && t < budget) begin
      @(negedge clk); #1; t++;
    end
    chk("drain_timeout", q.size(), 0);
    q.delete();
    req_a = '0;
  endtask

  task automatic settle(int budget);
    int t = 0;
    while ((busy_a || hit_a) && t < budget) begin
      @(negedge clk); #1; t++;
    end
    chk("settle_timeout", int'(busy_a), 0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  // Monitor for instance A: pops expected grants and checks timing.
  initial begin
    exp_t e;
    int   cyc = 0, last_fall = -1, hit_len = 0, bad_duty = 0, cur_duty = 0;
    bit   prev_hit = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_hit  = 1'b0;
        last_fall = -1;
      end else begin
        if (grant_a != '0) begin
          if (q.size() == 0) begin
            chk("unexpected_grant", int'(grant_a), 0);
          end else begin
            e = q.pop_front();
            chk("grant_onehot", int'(grant_a), 1 << e.idx);
            chk("owner", int'(owner_a), e.idx);
            chk("duty_load", int'(duty_cycle_a), e.duty);
            chk("hit_on", int'(hit_a), 1);
            chk("busy_on", int'(busy_a), 1);
            if (e.b2b && last_fall >= 0) chk("regrant_gap", cyc - last_fall, REST_CYC + 1);
            cur_duty = e.duty;
          end
          hit_len  = 0;
          bad_duty = 0;
        end
        if (hit_a) begin
          hit_len++;
          if (int'(duty_cycle_a) != cur_duty) bad_duty++;
        end
        if (prev_hit && !hit_a) begin
          chk("hit_len", hit_len, HOLD_CYC);
          chk("duty_hold", bad_duty, 0);
          chk("duty_off", int'(duty_cycle_a), 0);
          last_fall = cyc;
        end
        if (done_a) begin
          chk("done_time", cyc - last_fall, REST_CYC);
          chk("done_busy", int'(busy_a), 0);
          chk("done_hit", int'(hit_a), 0);
        end
        prev_hit = hit_a;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, g;
    int gt[3], go[3], gd[3];
    int gc, fall_t, done_t, done_hit;
    bit ph;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", int'(grant_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_owner", int'(owner_a), 0);
    chk("rst_duty", int'(duty_cycle_a), 0);
    chk("rst_hit", int'(hit_a), 0);
    reset = 1'b1;
    @(negedge clk); #1;

    // Single request, duty 50, requester 2.
    duty_a = '0;
    duty_a[14 +: 7] = 7'd50;
    push_round(4'b0100, 1);
    req_a = 4'b0100;
    drain(50);
    settle(1000);
    chk("owner_kept", int'(owner_a), last_a);

    // Clamp: duty 120 on requester 0.
    duty_a[0 +: 7] = 7'd120;
    push_round(4'b0001, 1);
    req_a = 4'b0001;
    drain(50);
    settle(1000);

    // All requesting, held through five grants.
    duty_a = 28'($urandom);
    push_round(4'b1111, 5);
    req_a = 4'b1111;
    drain(5 * 400);
    settle(1000);

    // Duty inputs change mid-strike; output must keep the latched value.
    duty_a = 28'($urandom);
    push_round(4'b1000, 1);
    req_a = 4'b1000;
    drain(50);
    repeat (50) @(negedge clk);
    #1;
    duty_a = ~duty_a;
    settle(1000);

    // Random request vectors, duties and hold counts.
    for (int r = 0; r < 8; r++) begin
      duty_a = 28'($urandom);
      v = int'($urandom_range(1, 15));
      g = int'($urandom_range(1, 3));
      push_round(v, g);
      req_a = 4'(v);
      drain(g * 400);
      settle(1000);
    end

    // Reset 37 cycles into a strike.
    duty_a = 28'($urandom);
    push_round(4'b0100, 1);
    req_a = 4'b0100;
    drain(50);
    repeat (36) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_hit", int'(hit_a), 0);
    chk("mid_rst_duty", int'(duty_cycle_a), 0);
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_grant", int'(grant_a), 0);
    chk("mid_rst_done", int'(done_a), 0);
    last_a = N - 1;
    last_b = N - 1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    push_round(4'b0010, 1);
    req_a = 4'b0010;
    drain(50);
    settle(1000);

    // Instance without rest: done with hit fall, re-grant one cycle later.
    gc = 0; fall_t = -1; done_t = -1; done_hit = 1; ph = 1'b0;
    gt = '{0, 0, 0}; go = '{0, 0, 0}; gd = '{0, 0, 0};
    req_b = 4'b0011;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (grant_b != '0 && gc < 3) begin
        gt[gc] = i; go[gc] = int'(owner_b); gd[gc] = int'(duty_cycle_b); gc++;
      end
      if (ph && !hit_b && fall_t < 0) fall_t = i;
      if (done_b && done_t < 0) begin
        done_t = i; done_hit = int'(hit_b);
      end
      ph = hit_b;
    end
    req_b = '0;
    chk("b_grant_count", gc, 3);
    for (int k = 0; k < 3; k++) begin
      last_b = pick(4'b0011, last_b);
      chk("b_owner", go[k], last_b);
      chk("b_duty", gd[k], 30);
    end
    chk("b_gap1", gt[1] - gt[0], HOLD_B * WIN_B + 1);
    chk("b_gap2", gt[2] - gt[1], HOLD_B * WIN_B + 1);
    chk("b_hit_len", fall_t - gt[0], HOLD_B * WIN_B);
    chk("b_done_edge", done_t - fall_t, 0);
    chk("b_done_hit", done_hit, 0);
    repeat (20) @(negedge clk);
    #1;

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_hit_scheduler.md
# pwm_hit_scheduler

Sequences the shared PWM serializer between several strike requesters. Each requester raises a request with a desired duty cycle. The scheduler grants one requester at a time and drives the serializer's `duty_cycle` and `hit` for a fixed strike time, then enforces a rest period before the next grant. It sits between the game/control logic and the single PWM serializer instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `SYS_FREQ`, 100, system clock in MHz.
- `PULSE_FREQ`, 1, PWM window rate in MHz; `WIN = SYS_FREQ/PULSE_FREQ` cycles per window.
- `HOLD_WINDOWS`, 20, strike length in windows (≥1).
- `REST_WINDOWS`, 10, rest length in windows (≥0).
- `DUTY_MAX`, 99, clamp ceiling for duty values.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `req`  in  NUM_REQ  level request per requester.
- `req_duty`  in  7*NUM_REQ  duty for requester i in bits [7i+6:7i].
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse on acceptance.
- `busy`  out  1  high in STRIKE or REST.
- `done`  out  1  one-cycle pulse when a strike/rest sequence ends.
- `owner`  out  $clog2(NUM_REQ)  index of the current or last grantee.
- `duty_cycle`  out  7  to serializer.
- `hit`  out  1  to serializer gate.

## Operation
- States: IDLE, STRIKE, REST.
- IDLE: if any `req` bit is high at a rising edge, select the winner, then on that edge:
  - load `duty_cycle = min(req_duty[winner], DUTY_MAX)`;
  - set `hit=1`, `grant[winner]=1`, `owner=winner`, `busy=1`;
  - enter STRIKE.
- Selection is round-robin. The search starts at `last_owner+1` mod NUM_REQ. The pointer updates only on a grant.
- STRIKE: `hit` and `duty_cycle` stay constant. `req` and `req_duty` are ignored. After HOLD_WINDOWS×WIN cycles:
  - if REST_WINDOWS>0: `hit=0`, `duty_cycle=0`, enter REST;
  - else: `hit=0`, `duty_cycle=0`, enter IDLE with `done=1`.
- REST: `hit=0`, `duty_cycle=0`. After REST_WINDOWS×WIN cycles, enter IDLE with `done=1` and `busy=0`.
- Cycle counter:
  - width is `$clog2(max(HOLD_WINDOWS,REST_WINDOWS)×WIN)+1`;
  - cleared on every state entry;
  - terminal count is N−1, with no wrap past terminal.
- A requester must drop `req` after its grant. A `req` still high on return to IDLE is re-eligible under round-robin order.
- Duty >127 is impossible (7 bits). Values DUTY_MAX+1..127 clamp to DUTY_MAX.

## Timing
- Reset (async, immediate):
  - `grant=0`, `busy=0`, `done=0`, `owner=0`, `duty_cycle=0`, `hit=0`;
  - state IDLE;
  - round-robin pointer set so that requester 0 has top priority.
- Reset mid-STRIKE drops `hit` at once. No `done` is issued.
- Grant latency: `req` high at edge k gives `grant`/`hit` high from edge k to k+1 (grant) and k to k+HOLD_WINDOWS×WIN (hit).
- `hit` is high for exactly HOLD_WINDOWS×WIN cycles.
- `done` is high for one cycle: the first IDLE cycle.
- Earliest re-grant is the edge ending that cycle. The gap from `hit` low to the next `hit` high is REST_WINDOWS×WIN+1 cycles.
- Simultaneous requests: exactly one grant per IDLE edge. The others wait with `req` held.
- All outputs are registered. There is no combinational path from `req` to outputs.

## Configuration
- `PWM_SCHED_FIXED_PRIORITY_EN`:
  - defined: fixed priority, lowest index wins; the round-robin pointer is removed.
  - undefined (default): round-robin as above.

## Test plan
- Single request: `req=4'b0100`, duty 50, WIN=100, HOLD=2, REST=1. Expect:
  - `grant=4'b0100` for one cycle;
  - `hit=1`, `duty_cycle=50` for 200 cycles;
  - `hit=0` for 100 cycles;
  - `done` pulse; `owner=2`.
- Clamp: duty 120 with DUTY_MAX=99 → `duty_cycle=99` throughout STRIKE.
- Round-robin: `req=4'b1111` held continuously.
  - Expect grants in order 0,1,2,3,0.
  - Each next grant occurs exactly REST×WIN+1 cycles after the previous `hit` falls.
  - With `PWM_SCHED_FIXED_PRIORITY_EN`: grants are always 0.
- REST_WINDOWS=0: `hit` falls and `done` pulses on the same edge. A pending request re-grants one cycle later.
- Reset mid-STRIKE: pull `reset` low 37 cycles into STRIKE.
  - Expect `hit`, `duty_cycle`, `busy`, `grant` = 0 immediately, with no `done`.
  - After release with `req=4'b0010`, expect `grant=4'b0010`.
- Request change during STRIKE: change `req_duty` mid-strike → `duty_cycle` remains at the latched value.
